// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: FSM state encoding and
// the widths of the bubble counter and the performance counters.
package hazard_unit_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } hazard_state_e;

  localparam int CNT_W  = 2;
  localparam int PERF_W = 16;
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping,
// cleared asynchronously by the active-low reset.
module sat_counter16
  import hazard_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  output logic [PERF_W-1:0] count_o
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != PERF_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter16

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use bubble insertion with a programmable bubble
// count, IF/ID squash on taken branches/jumps, and stall/flush statistics.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_ID_EX,
  input  logic [4:0]        rd_ID_EX,
  input  logic [4:0]        rs1_IF_ID,
  input  logic [4:0]        rs2_IF_ID,
  input  logic              useRs1,
  input  logic              useRs2,
  input  logic              branchTaken_EX,
  input  logic              jump_ID_EX,
  output logic              stall,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              flush_IF_ID,
  output logic              busy,
  output logic [PERF_W-1:0] stallCount,
  output logic [PERF_W-1:0] flushCount
);

  if ((LOAD_USE_CYCLES < 1) || (LOAD_USE_CYCLES > 4)) begin : g_bad_load_use_cycles
    $fatal(1, "hazard_unit: LOAD_USE_CYCLES must be in 1..4");
  end

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_USE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

  hazard_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             redirect;

  assign hazard = memRead_ID_EX && (rd_ID_EX != 5'd0) &&
                  ((useRs1 && (rd_ID_EX == rs1_IF_ID)) ||
                   (useRs2 && (rd_ID_EX == rs2_IF_ID)));
  assign redirect = branchTaken_EX || jump_ID_EX;

  // While reset is held the outputs stay at their free-running values even if
  // the hazard inputs are active, so gate everything on reset here.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    flush_IF_ID = 1'b0;
    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (redirect) begin
            flush_IF_ID = 1'b1;
            stall       = 1'b1;
          end else if (hazard) begin
            stall     = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            if (LOAD_USE_CYCLES > 1) begin
              state_d = LU_WAIT;
              cnt_d   = CNT_RELOAD;
            end
          end
        end
        LU_WAIT: begin
          stall     = 1'b1;
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == LU_WAIT);

  // A redirect also raises stall, but that cycle is counted as a flush only.
  sat_counter16 u_stallCounter (
    .clk     (clk),
    .reset   (reset),
    .en_i    (stall && !flush_IF_ID),
    .count_o (stallCount)
  );

  sat_counter16 u_flushCounter (
    .clk     (clk),
    .reset   (reset),
    .en_i    (flush_IF_ID),
    .count_o (flushCount)
  );

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (1, 3 and 4 bubbles) share one
// stimulus stream and are compared against a bubble-count reference model.
module tb_hazard_unit;

  localparam int N = 3;
  localparam int LCYC [N] = '{1, 3, 4};

  logic       clk = 1'b0;
  logic       rstN;
  logic       memRead;
  logic [4:0] rd, rs1, rs2;
  logic       useRs1, useRs2, branchTaken, jump;

  logic [N-1:0] stallW, pcWriteW, ifidWriteW, flushW, busyW;
  logic [15:0]  stallCntW [N];
  logic [15:0]  flushCntW [N];

  int assertCount = 0;
  int failCount   = 0;

  int modelRem   [N];
  int modelStall [N];
  int modelFlush [N];

  always #5 clk = ~clk;

  hazard_unit #(.LOAD_USE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rstN), .memRead_ID_EX(memRead), .rd_ID_EX(rd),
    .rs1_IF_ID(rs1), .rs2_IF_ID(rs2), .useRs1(useRs1), .useRs2(useRs2),
    .branchTaken_EX(branchTaken), .jump_ID_EX(jump),
    .stall(stallW[0]), .pcWrite(pcWriteW[0]), .ifidWrite(ifidWriteW[0]),
    .flush_IF_ID(flushW[0]), .busy(busyW[0]),
    .stallCount(stallCntW[0]), .flushCount(flushCntW[0])
  );

  hazard_unit #(.LOAD_USE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rstN), .memRead_ID_EX(memRead), .rd_ID_EX(rd),
    .rs1_IF_ID(rs1), .rs2_IF_ID(rs2), .useRs1(useRs1), .useRs2(useRs2),
    .branchTaken_EX(branchTaken), .jump_ID_EX(jump),
    .stall(stallW[1]), .pcWrite(pcWriteW[1]), .ifidWrite(ifidWriteW[1]),
    .flush_IF_ID(flushW[1]), .busy(busyW[1]),
    .stallCount(stallCntW[1]), .flushCount(flushCntW[1])
  );

  hazard_unit #(.LOAD_USE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(rstN), .memRead_ID_EX(memRead), .rd_ID_EX(rd),
    .rs1_IF_ID(rs1), .rs2_IF_ID(rs2), .useRs1(useRs1), .useRs2(useRs2),
    .branchTaken_EX(branchTaken), .jump_ID_EX(jump),
    .stall(stallW[2]), .pcWrite(pcWriteW[2]), .ifidWrite(ifidWriteW[2]),
    .flush_IF_ID(flushW[2]), .busy(busyW[2]),
    .stallCount(stallCntW[2]), .flushCount(flushCntW[2])
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit refHazard();
    return memRead && (rd != 5'd0) &&
           ((useRs1 && (rd == rs1)) || (useRs2 && (rd == rs2)));
  endfunction

  function automatic int satInc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic setIdle();
    memRead = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    useRs1 = 1'b0; useRs2 = 1'b0; branchTaken = 1'b0; jump = 1'b0;
  endtask

  task automatic setLoadUse(input logic [4:0] r);
    memRead = 1'b1; rd = r; rs1 = r; rs2 = 5'd0;
    useRs1 = 1'b1; useRs2 = 1'b0; branchTaken = 1'b0; jump = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; checks the model's
  // view of this cycle and then advances the model across the rising edge.
  task automatic applyStimulus(input bit doCheck);
    bit expStall, expPc, expIfid, expFlush, expBusy;
    bit haz, redir;
    #1;
    haz   = refHazard();
    redir = branchTaken || jump;
    for (int i = 0; i < N; i++) begin
      if (!rstN) begin
        modelRem[i] = 0; modelStall[i] = 0; modelFlush[i] = 0;
      end
      expBusy  = (modelRem[i] > 0);
      expStall = 1'b0; expPc = 1'b1; expIfid = 1'b1; expFlush = 1'b0;
      if (rstN) begin
        if (modelRem[i] > 0) begin
          expStall = 1'b1; expPc = 1'b0; expIfid = 1'b0;
        end else if (redir) begin
          expStall = 1'b1; expFlush = 1'b1;
        end else if (haz) begin
          expStall = 1'b1; expPc = 1'b0; expIfid = 1'b0;
        end
      end
      if (doCheck) begin
        checkOutput($sformatf("stall[L%0d]", LCYC[i]), 16'(stallW[i]), 16'(expStall));
        checkOutput($sformatf("pcWrite[L%0d]", LCYC[i]), 16'(pcWriteW[i]), 16'(expPc));
        checkOutput($sformatf("ifidWrite[L%0d]", LCYC[i]), 16'(ifidWriteW[i]), 16'(expIfid));
        checkOutput($sformatf("flush[L%0d]", LCYC[i]), 16'(flushW[i]), 16'(expFlush));
        checkOutput($sformatf("busy[L%0d]", LCYC[i]), 16'(busyW[i]), 16'(expBusy));
        checkOutput($sformatf("stallCount[L%0d]", LCYC[i]), stallCntW[i], 16'(modelStall[i]));
        checkOutput($sformatf("flushCount[L%0d]", LCYC[i]), flushCntW[i], 16'(modelFlush[i]));
      end
      if (rstN) begin
        if (expStall && !expFlush) modelStall[i] = satInc(modelStall[i]);
        if (expFlush) modelFlush[i] = satInc(modelFlush[i]);
        if (modelRem[i] > 0) modelRem[i] = modelRem[i] - 1;
        else if (!redir && haz) modelRem[i] = LCYC[i] - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      modelRem[i] = 0; modelStall[i] = 0; modelFlush[i] = 0;
    end
    setIdle();
    rstN = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    rstN = 1'b1;
    applyStimulus(1'b1);

    $display("[TB] load-use with 1, 3 and 4 bubbles");
    setLoadUse(5'd5);
    applyStimulus(1'b1);
    setIdle();
    for (int c = 0; c < 5; c++) applyStimulus(1'b1);
    checkOutput("stallCount after load-use L1", stallCntW[0], 16'd1);
    checkOutput("stallCount after load-use L3", stallCntW[1], 16'd3);
    checkOutput("stallCount after load-use L4", stallCntW[2], 16'd4);

    $display("[TB] x0 destination and unused source");
    memRead = 1'b1; rd = 5'd0; rs1 = 5'd0; useRs1 = 1'b1;
    applyStimulus(1'b1);
    memRead = 1'b1; rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; useRs1 = 1'b1; useRs2 = 1'b0;
    applyStimulus(1'b1);
    setIdle();
    applyStimulus(1'b1);
    checkOutput("stallCount unchanged x0/unused L3", stallCntW[1], 16'd3);

    $display("[TB] branch taken together with load-use");
    rstN = 1'b0;
    applyStimulus(1'b1);
    rstN = 1'b1;
    setLoadUse(5'd9);
    branchTaken = 1'b1;
    applyStimulus(1'b1);
    setIdle();
    applyStimulus(1'b1);
    checkOutput("flushCount after redirect L4", flushCntW[2], 16'd1);
    checkOutput("stallCount after redirect L4", stallCntW[2], 16'd0);
    checkOutput("busy after redirect L4", 16'(busyW[2]), 16'd0);

    $display("[TB] reset during LU_WAIT");
    setLoadUse(5'd12);
    applyStimulus(1'b1);
    setIdle();
    checkOutput("busy in bubble 2 L4", 16'(busyW[2]), 16'd1);
    rstN = 1'b0;
    applyStimulus(1'b1);
    checkOutput("busy during reset L4", 16'(busyW[2]), 16'd0);
    rstN = 1'b1;
    for (int c = 0; c < 2; c++) applyStimulus(1'b1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      memRead     = 1'($urandom_range(0, 1));
      rd          = 5'($urandom_range(0, 3));
      rs1         = 5'($urandom_range(0, 3));
      rs2         = 5'($urandom_range(0, 3));
      useRs1      = 1'($urandom_range(0, 1));
      useRs2      = 1'($urandom_range(0, 1));
      branchTaken = ($urandom_range(0, 7) == 0);
      jump        = ($urandom_range(0, 7) == 0);
      rstN        = ($urandom_range(0, 49) != 0);
      applyStimulus(1'b1);
    end
    rstN = 1'b1;

    $display("[TB] counter saturation");
    rstN = 1'b0;
    setIdle();
    applyStimulus(1'b1);
    rstN = 1'b1;
    setLoadUse(5'd1);
    for (int c = 0; c < 65540; c++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("stallCount saturated L1", stallCntW[0], 16'hFFFF);
    checkOutput("stallCount saturated L4", stallCntW[2], 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_hazard_unit
